// File: rtl/inv_cipher_core_pkg.sv
// Shared AES inverse-cipher definitions: state layout, key-size round counts,
// inverse S-box, GF(2^8) helpers and vector/state byte-order conversion.
package inv_cipher_core_pkg;

   localparam int unsigned NR_AES128 = 10;
   localparam int unsigned NR_AES192 = 12;
   localparam int unsigned NR_AES256 = 14;

   // s[c][r]: column c, row r; byte 4c+r of the 128-bit vector counted from the MSB
   typedef logic [3:0][3:0][7:0] state_t;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0;
      x = a;
      y = b;
      for (int unsigned i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // Byte reversal maps vector byte k (from MSB) onto packed element k (from LSB)
   function automatic state_t to_state(input logic [127:0] v);
      return state_t'({<<8{v}});
   endfunction

   function automatic logic [127:0] from_state(input state_t s);
      return {<<8{s}};
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] v);
      logic [127:0] o;
      o = '0;
      for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = INV_SBOX[v[8*i +: 8]];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] v);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = v[127-32*c -: 8];
         a1 = v[119-32*c -: 8];
         a2 = v[111-32*c -: 8];
         a3 = v[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

endpackage

// File: rtl/inv_cipher_core_inv_shift_rows.sv
// AES InvShiftRows: row r of the state rotates right by r columns.
module inv_shift_rows
   import inv_cipher_core_pkg::*;
(
   input  state_t state,
   output state_t shifted
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign shifted[c][r] = state[(c - r + 4) % 4][r];
      end
   end

endmodule

// File: rtl/inv_cipher_core.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched by index.
// Optional abort input enabled with `define INV_CIPHER_ABORT_EN.
module inv_cipher_core
   import inv_cipher_core_pkg::*;
#(
   parameter int unsigned NR = NR_AES128
)(
   input  logic         clk,
   input  logic         rst,
`ifdef INV_CIPHER_ABORT_EN
   input  logic         abort,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   fsm_t         fsm, fsm_nxt;
   logic [127:0] data, data_nxt;
   logic [3:0]   round, round_nxt;
   state_t       shifted;
   logic [127:0] t;

   inv_shift_rows u_inv_shift_rows (
      .state   (to_state(data)),
      .shifted (shifted)
   );

   assign t        = inv_sub_bytes(from_state(shifted)) ^ rk;
   assign out_data = data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm   <= IDLE;
         data  <= '0;
         round <= '0;
      end else begin
         fsm   <= fsm_nxt;
         data  <= data_nxt;
         round <= round_nxt;
      end
   end

   always_comb begin
      fsm_nxt   = fsm;
      data_nxt  = data;
      round_nxt = round;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_idx    = 4'(NR);
      unique case (fsm)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_nxt  = in_data ^ rk;
               round_nxt = 4'(NR - 1);
               fsm_nxt   = ROUND;
            end
         end
         ROUND: begin
            rk_idx = round;
            // Final round skips InvMixColumns and leaves the counter parked at zero
            if (round != 4'd0) begin
               data_nxt  = inv_mix_columns(t);
               round_nxt = round - 4'd1;
            end else begin
               data_nxt = t;
               fsm_nxt  = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_nxt = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
`ifdef INV_CIPHER_ABORT_EN
      if (abort && fsm != IDLE) fsm_nxt = IDLE;
`endif
   end

endmodule

// File: tb/tb_inv_cipher_core.sv
// Scoreboard bench: blocks are encrypted by a forward-cipher model, decrypted by the DUT.
module tb_inv_cipher_core;
   import inv_cipher_core_pkg::*;

   localparam int unsigned NR = 10;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_ready, out_valid;
   logic [127:0] rk, out_data;
   logic [3:0]   rk_idx;
`ifdef INV_CIPHER_ABORT_EN
   logic         abort = 1'b0;
`endif

   logic [127:0] rks [16];
   assign rk = rks[rk_idx];

   state_t isr_in, isr_out;

   inv_cipher_core #(.NR(NR)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef INV_CIPHER_ABORT_EN
      .abort     (abort),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_idx    (rk_idx),
      .rk        (rk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   inv_shift_rows isr (
      .state   (isr_in),
      .shifted (isr_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass = 0;

   logic [7:0]   sbox [256];
   logic [127:0] q [$];
   int           aq [$];
   logic [127:0] cur_exp = '0;
   int           accepts = 0;
   bit           prev_valid = 0;
   bit           expect_idle = 0;
   bit           rdy_rand = 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   function automatic int gm(input int a, input int b);
      int p = 0;
      for (int i = 0; i < 8; i++) begin
         if ((b & 1) != 0) p = p ^ a;
         a = a << 1;
         if ((a & 256) != 0) a = a ^ 283;
         b = b >> 1;
      end
      return p & 255;
   endfunction

   function automatic int rotl8(input int b, input int n);
      return ((b << n) | (b >> (8 - n))) & 255;
   endfunction

   // Forward S-box from its definition: multiplicative inverse then affine map
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         int inv = 0;
         int s;
         for (int y = 1; y < 256; y++) if (gm(x, y) == 1) inv = y;
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x] = 8'(s);
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = 8'(gm(int'(rcon), 2));
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rks[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [127:0] s;
      s = pt ^ rks[0];
      for (int rnd = 1; rnd <= int'(NR); rnd++) begin
         for (int k = 0; k < 16; k++) b[k] = sbox[s[127-8*k -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
         if (rnd != int'(NR)) begin
            for (int c = 0; c < 4; c++) begin
               b[4*c]   = 8'(gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3]);
               b[4*c+1] = 8'(t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3]);
               b[4*c+2] = 8'(t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3));
               b[4*c+3] = 8'(gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2));
            end
         end else begin
            for (int k = 0; k < 16; k++) b[k] = t[k];
         end
         for (int k = 0; k < 16; k++) s[127-8*k -: 8] = b[k];
         s = s ^ rks[rnd];
      end
      return s;
   endfunction

   function automatic logic [127:0] isr_model(input logic [127:0] v);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = v[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   // Monitor: the scoreboard head is the plaintext the DUT must present next
   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
         aq.delete();
         prev_valid = 0;
         expect_idle = 0;
      end else begin
         if (expect_idle) begin
            expect_idle = 0;
            chk("idle_next_cycle", {126'd0, in_ready, out_valid}, 128'b10);
         end
`ifdef INV_CIPHER_ABORT_EN
         if (abort && !in_ready) begin
            q.delete();
            aq.delete();
            prev_valid = 0;
            expect_idle = 1;
         end else
`endif
         begin
            if (out_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_out_valid", {127'd0, out_valid}, '0);
               end else begin
                  chk("out_data", out_data, q[0]);
                  chk("in_ready_low_while_valid", {127'd0, in_ready}, '0);
                  if (!prev_valid) chk("latency", 128'(cyc - aq[0]), 128'(NR));
                  if (out_ready) begin
                     void'(q.pop_front());
                     void'(aq.pop_front());
                     expect_idle = 1;
                  end
               end
            end
            prev_valid = out_valid && !out_ready;
            if (in_valid && in_ready) begin
               chk("accept_only_when_empty", 128'(q.size()), '0);
               q.push_back(cur_exp);
               aq.push_back(cyc + 1);
               accepts++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [127:0] ct, input logic [127:0] pt);
      int  n0;
      bit  done = 0;
      cur_exp  = pt;
      in_data  = ct;
      in_valid = 1'b1;
      n0 = accepts;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk);
         #1;
         if (accepts != n0) done = 1;
      end
      if (!done) fail("accept_timeout");
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (q.size() == 0 && in_ready && !out_valid) done = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) fail("drain_timeout");
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready_valid"}, {126'd0, in_ready, out_valid}, 128'b10);
      chk({tag, "_out_data"}, out_data, '0);
      chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(NR));
   endtask

   initial begin
      logic [127:0] v, pt, ct, key;
      bit got;
      build_sbox();
      for (int i = 0; i < 16; i++) rks[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst = 1'b1;

      isr_in = to_state(128'h000102030405060708090a0b0c0d0e0f);
      #1;
      chk("inv_shift_rows_vec", from_state(isr_out), 128'h000d0a0704010e0b0805020f0c090603);
      for (int i = 0; i < 4; i++) begin
         v = {$urandom, $urandom, $urandom, $urandom};
         isr_in = to_state(v);
         #1;
         chk("inv_shift_rows_rand", from_state(isr_out), isr_model(v));
      end

      load_key(C1_KEY);
      @(posedge clk);
      #1;
      send(C1_CT, C1_PT);
      in_valid = 1'b0;
      drain();

      // Backpressure: hold out_ready low for 20 cycles, then a single pulse
      rdy_rand = 0;
      out_ready = 1'b0;
      send(C1_CT, C1_PT);
      in_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) got = 1;
      end
      if (!got) fail("bp_out_valid_timeout");
      repeat (20) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      drain();
      rdy_rand = 1;

      // Back-to-back with in_valid held high
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = encrypt(pt);
      send(C1_CT, C1_PT);
      send(ct, pt);
      in_valid = 1'b0;
      drain();

      // Reset in the middle of round 5
      send(C1_CT, C1_PT);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset_vals("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      send(C1_CT, C1_PT);
      in_valid = 1'b0;
      drain();

`ifdef INV_CIPHER_ABORT_EN
      send(C1_CT, C1_PT);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      send(C1_CT, C1_PT);
      in_valid = 1'b0;
      drain();
`endif

      for (int n = 0; n < 20; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         load_key(key);
         pt = {$urandom, $urandom, $urandom, $urandom};
         ct = encrypt(pt);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send(ct, pt);
         in_valid = 1'b0;
         drain();
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
